// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared constants and entry type for the fetch/decode queue
package if_id_queue_pkg;

    localparam int XLEN          = 32;
    localparam int DEFAULT_DEPTH = 4;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } iq_entry_t;

endpackage

// File: rtl/iq_storage.sv
// rtl/iq_storage.sv - entry register array with one write port and one async read port
module iq_storage
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [PW-1:0]   waddr,
    input  iq_entry_t       wdata,
    input  logic [PW-1:0]   raddr,
    output iq_entry_t       rdata
);

    // Contents are never reset; validity is tracked by the controller's count.
    iq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch-to-decode instruction queue with replay, JAL and flush redirects
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int N     = XLEN,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] instr_in,
    input  logic [N-1:0] pc4_in,
    output logic         PCsrc,
    output logic [N-1:0] PCimm,
    input  logic         flush_valid,
    input  logic [N-1:0] flush_target,
    output logic         id_valid,
    input  logic         id_ready,
    output logic [N-1:0] id_instr,
    output logic [N-1:0] id_pc,
    output logic [N-1:0] id_pc4
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          push;
    logic          is_jal;
    logic [N-1:0]  pc_cur;
    logic [N-1:0]  jal_offset;
    logic [N-1:0]  jal_target;
    iq_entry_t     wr_entry;
    iq_entry_t     rd_entry;

    assign id_valid = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = id_valid & id_ready & ~flush_valid;
    // A full queue still takes the new word when the head leaves in the same cycle.
    assign push     = ~flush_valid & (~full | pop);

    assign pc_cur     = pc4_in - N'(4);
    assign jal_offset = {{(N-21){instr_in[31]}}, instr_in[31], instr_in[19:12],
                         instr_in[20], instr_in[30:21], 1'b0};
    assign jal_target = pc_cur + jal_offset;
    assign is_jal     = (instr_in[6:0] == OPC_JAL);

    always_comb begin
        PCsrc = 1'b0;
        PCimm = '0;
        if (!reset) begin
            if (flush_valid) begin
                PCsrc = 1'b1;
                PCimm = flush_target;
            end else if (!push) begin
                // Word dropped: point fetch back at the same PC.
                PCsrc = 1'b1;
                PCimm = pc_cur;
            end else if (is_jal) begin
                PCsrc = 1'b1;
                PCimm = jal_target;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign wr_entry = '{instr: instr_in, pc: pc_cur, pc4: pc4_in};

    iq_storage #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    assign id_instr = id_valid ? rd_entry.instr : '0;
    assign id_pc    = id_valid ? rd_entry.pc    : '0;
    assign id_pc4   = id_valid ? rd_entry.pc4   : '0;

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue with directed fetch/decode vectors
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] JAL = 32'h0100_006F;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_in;
    logic [31:0] pc4_in;
    logic        PCsrc;
    logic [31:0] PCimm;
    logic        flush_valid;
    logic [31:0] flush_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [95:0] sb [$];

    if_id_queue #(.N(32), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_in     (instr_in),
        .pc4_in       (pc4_in),
        .PCsrc        (PCsrc),
        .PCimm        (PCimm),
        .flush_valid  (flush_valid),
        .flush_target (flush_target),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_pc4       (id_pc4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One fetch cycle: drive, check redirect and head-valid at negedge, record expected push.
    task automatic step(input logic [31:0] ins, input logic [31:0] p4, input logic rdy,
                        input logic fl, input logic [31:0] ft, input logic acc,
                        input logic ps, input logic [31:0] pi, input logic v);
        instr_in     = ins;
        pc4_in       = p4;
        id_ready     = rdy;
        flush_valid  = fl;
        flush_target = ft;
        @(negedge clk);
        check("pcsrc", {31'd0, PCsrc}, {31'd0, ps});
        check("pcimm", PCimm, pi);
        check("id_valid", {31'd0, id_valid}, {31'd0, v});
        if (!v) begin
            check("empty_id_pc", id_pc, 32'd0);
            check("empty_id_instr", id_instr, 32'd0);
        end
        #1;
        if (acc) sb.push_back({ins, p4 - 32'd4, p4});
        @(posedge clk);
        #1;
        if (fl) sb.delete();
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    initial begin
        logic [95:0] e;
        forever begin
            @(negedge clk);
            if (!reset && id_valid && id_ready && !flush_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got pc %h expected no entry", id_pc);
                end else begin
                    e = sb.pop_front();
                    check("head_instr", id_instr, e[95:64]);
                    check("head_pc", id_pc, e[63:32]);
                    check("head_pc4", id_pc4, e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        instr_in     = JAL;
        pc4_in       = 32'h100;
        id_ready     = 1'b1;
        flush_valid  = 1'b0;
        flush_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_pcsrc", {31'd0, PCsrc}, 32'd0);
        check("rst_pcimm", PCimm, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        reset = 1'b0;

        // In-order stream, decode always ready
        step(NOP, 32'd4,  1, 0, 0, 1, 0, 32'd0, 0);
        step(NOP, 32'd8,  1, 0, 0, 1, 0, 32'd0, 1);
        step(NOP, 32'd12, 1, 0, 0, 1, 0, 32'd0, 1);

        // Empty the queue, then stall decode until full and replay
        step(NOP, 32'd16, 1, 1, 32'd0, 0, 1, 32'd0, 1);
        step(NOP, 32'd4,  0, 0, 0, 1, 0, 32'd0, 0);
        step(NOP, 32'd8,  0, 0, 0, 1, 0, 32'd0, 1);
        step(NOP, 32'd12, 0, 0, 0, 1, 0, 32'd0, 1);
        step(NOP, 32'd16, 0, 0, 0, 1, 0, 32'd0, 1);
        step(NOP, 32'd20, 0, 0, 0, 0, 1, 32'd16, 1);
        step(NOP, 32'd20, 0, 0, 0, 0, 1, 32'd16, 1);
        step(NOP, 32'd20, 1, 0, 0, 1, 0, 32'd0, 1);
        step(NOP, 32'd24, 1, 0, 0, 1, 0, 32'd0, 1);
        // Full + pop + JAL: accepted, JAL target wins over replay
        step(JAL, 32'd28, 1, 0, 0, 1, 1, 32'd40, 1);

        // Flush, then JAL at pc4 0x24 into a non-full queue
        step(NOP, 32'd44,   1, 1, 32'h20, 0, 1, 32'h20, 1);
        step(JAL, 32'h24,   0, 0, 0, 1, 1, 32'h30, 0);
        step(NOP, 32'h34,   0, 0, 0, 1, 0, 32'd0, 1);
        step(NOP, 32'h38,   0, 0, 0, 1, 0, 32'd0, 1);
        // Flush with 3 entries and a JAL on the same cycle
        step(JAL, 32'h3C,   1, 1, 32'h200, 0, 1, 32'h200, 1);
        step(NOP, 32'h204,  1, 0, 0, 1, 0, 32'd0, 0);
        step(NOP, 32'h208,  1, 0, 0, 1, 0, 32'd0, 1);
        step(NOP, 32'h20C,  0, 0, 0, 1, 0, 32'd0, 1);
        step(NOP, 32'h210,  0, 0, 0, 1, 0, 32'd0, 1);

        // Short asynchronous reset with 3 entries held
        reset    = 1'b1;
        instr_in = JAL;
        pc4_in   = 32'h214;
        #1;
        check("pulse_id_valid", {31'd0, id_valid}, 32'd0);
        check("pulse_pcsrc", {31'd0, PCsrc}, 32'd0);
        check("pulse_pcimm", PCimm, 32'd0);
        check("pulse_id_pc", id_pc, 32'd0);
        #2;
        reset = 1'b0;
        sb.delete();
        step(NOP, 32'd4,  1, 0, 0, 1, 0, 32'd0, 0);
        step(NOP, 32'd8,  1, 0, 0, 1, 0, 32'd0, 1);
        step(NOP, 32'd12, 1, 0, 0, 1, 0, 32'd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
